// File: rtl/npc_pkg.sv
// ---------------------------------------------------------------------------
// npc_pkg
// Shared constants for the write-back path: datapath and register-address
// widths, register count, and the RV32 load funct3 encodings used by the
// load formatter.
// ---------------------------------------------------------------------------
package npc_pkg;

    localparam int XLEN    = 32;
    localparam int REG_AW  = 5;
    localparam int NR_REGS = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/npc_wbu_chk.sv
// ---------------------------------------------------------------------------
// npc_wbu_chk
// Protocol checker for the write-back scoreboard interface. Flags an issue to
// a destination that still has a write pending (the decoder must stall on
// WAW), and checks that x0 is never marked busy.
// Ports:
//   clk, rst   in  clock and synchronous active-high reset
//   iss_valid  in  issue strobe from decode
//   iss_rd     in  issued destination register
//   busy       in  scoreboard vector from npc_wbu
// ---------------------------------------------------------------------------
module npc_wbu_chk
    import npc_pkg::*;
(
    input logic              clk,
    input logic              rst,
    input logic              iss_valid,
    input logic [REG_AW-1:0] iss_rd,
    input logic [NR_REGS-1:0] busy
);

    // Issue to a destination with a pending write is a decode-side bug.
    a_no_waw_issue: assert property (@(posedge clk) disable iff (rst)
        !(iss_valid && (iss_rd != 5'd0) && busy[iss_rd]));

    // x0 never carries a pending write.
    a_x0_never_busy: assert property (@(posedge clk) disable iff (rst)
        (busy[0] == 1'b0));

endmodule

// File: rtl/npc_wbu_ldfmt.sv
// ---------------------------------------------------------------------------
// npc_wbu_ldfmt
// Combinational load formatter. Extracts the addressed byte/halfword from an
// aligned memory word and sign- or zero-extends it to XLEN.
// Ports:
//   word  in  XLEN  raw aligned memory word
//   off   in  2     byte offset (addr[1:0]); halfword uses off[1] only
//   f3    in  3     load funct3 (LB/LH/LW/LBU/LHU); others pass word through
//   data  out XLEN  formatted register value
// ---------------------------------------------------------------------------
module npc_wbu_ldfmt
    import npc_pkg::*;
(
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      off,
    input  logic [2:0]      f3,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed byte lane.
    always_comb begin
        byte_s = 8'h00;
        case (off)
            2'd0:    byte_s = word[7:0];
            2'd1:    byte_s = word[15:8];
            2'd2:    byte_s = word[23:16];
            2'd3:    byte_s = word[31:24];
            default: byte_s = 8'h00;
        endcase
    end

    // Select the addressed halfword; the low offset bit is a don't-care.
    always_comb begin
        half_s = 16'h0000;
        if (off[1]) begin
            half_s = word[31:16];
        end else begin
            half_s = word[15:0];
        end
    end

    // Extend the selected field according to the load type.
    always_comb begin
        data = word;
        case (f3)
            F3_LB:   data = {{24{byte_s[7]}}, byte_s};
            F3_LBU:  data = {24'h000000, byte_s};
            F3_LH:   data = {{16{half_s[15]}}, half_s};
            F3_LHU:  data = {16'h0000, half_s};
            F3_LW:   data = word;
            default: data = word;
        endcase
    end

endmodule

// File: rtl/npc_wbu.sv
// ---------------------------------------------------------------------------
// npc_wbu
// Write-back unit feeding the 32-entry register file. Arbitrates EXU and LSU
// results (one per cycle, round-robin under contention), formats load data,
// registers a single RF write per cycle and maintains the pending-write
// scoreboard used by decode for hazard stalls.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   iss_valid, iss_rd          decode issued an instr writing iss_rd
//   busy                       busy[r]=1 while a write to r is pending
//   exu_valid/ready/rd/data    ALU result channel
//   lsu_valid/ready/rd/rdata   load result channel (raw aligned word)
//   lsu_off, lsu_funct3        byte offset and load type for formatting
//   rf_wen, rf_waddr, rf_wdata registered RF write port
//   commit                     one-cycle pulse per retired result (incl. x0)
// ---------------------------------------------------------------------------
module npc_wbu
    import npc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               iss_valid,
    input  logic [REG_AW-1:0]  iss_rd,
    output logic [NR_REGS-1:0] busy,
    input  logic               exu_valid,
    output logic               exu_ready,
    input  logic [REG_AW-1:0]  exu_rd,
    input  logic [XLEN-1:0]    exu_data,
    input  logic               lsu_valid,
    output logic               lsu_ready,
    input  logic [REG_AW-1:0]  lsu_rd,
    input  logic [XLEN-1:0]    lsu_rdata,
    input  logic [1:0]         lsu_off,
    input  logic [2:0]         lsu_funct3,
    output logic               rf_wen,
    output logic [REG_AW-1:0]  rf_waddr,
    output logic [XLEN-1:0]    rf_wdata,
    output logic               commit
);

    logic               rr_ptr_r;      // 0: EXU wins next tie, 1: LSU wins
    logic               exu_gnt_s;
    logic               lsu_gnt_s;
    logic               accept_s;
    logic [REG_AW-1:0]  win_rd_s;
    logic [XLEN-1:0]    win_data_s;
    logic [XLEN-1:0]    ld_data_s;
    logic [NR_REGS-1:0] busy_r;
    logic [NR_REGS-1:0] busy_nxt_s;

    npc_wbu_ldfmt u_ldfmt (
        .word (lsu_rdata),
        .off  (lsu_off),
        .f3   (lsu_funct3),
        .data (ld_data_s)
    );

    // Grant at most one source per cycle; ties resolved by rr_ptr_r.
    always_comb begin
        exu_gnt_s = 1'b0;
        lsu_gnt_s = 1'b0;
        if (rst) begin
            exu_gnt_s = 1'b0;
            lsu_gnt_s = 1'b0;
        end else if (exu_valid && lsu_valid) begin
            exu_gnt_s = ~rr_ptr_r;
            lsu_gnt_s = rr_ptr_r;
        end else begin
            exu_gnt_s = exu_valid;
            lsu_gnt_s = lsu_valid;
        end
    end

    assign exu_ready = exu_gnt_s;
    assign lsu_ready = lsu_gnt_s;
    assign accept_s  = exu_gnt_s | lsu_gnt_s;

    // Route the granted payload toward the output register.
    always_comb begin
        win_rd_s   = 5'd0;
        win_data_s = 32'h0000_0000;
        if (lsu_gnt_s) begin
            win_rd_s   = lsu_rd;
            win_data_s = ld_data_s;
        end else begin
            win_rd_s   = exu_rd;
            win_data_s = exu_data;
        end
    end

    // Scoreboard next state: clear on the RF write edge, set on issue.
    always_comb begin
        busy_nxt_s = busy_r;
        if (rf_wen) begin
            busy_nxt_s[rf_waddr] = 1'b0;
        end else begin
            busy_nxt_s = busy_r;
        end
        if (iss_valid && (iss_rd != 5'd0)) begin
            busy_nxt_s[iss_rd] = 1'b1;
        end else begin
            busy_nxt_s[0] = 1'b0;
        end
        busy_nxt_s[0] = 1'b0;
    end

    // Output register, round-robin pointer and scoreboard state.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen   <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= 32'h0000_0000;
            commit   <= 1'b0;
            rr_ptr_r <= 1'b0;
            busy_r   <= 32'h0000_0000;
        end else begin
            // x0 results retire (commit) but never write the RF.
            rf_wen <= accept_s && (win_rd_s != 5'd0);
            commit <= accept_s;
            if (accept_s) begin
                rf_waddr <= win_rd_s;
                rf_wdata <= win_data_s;
            end else begin
                rf_waddr <= rf_waddr;
                rf_wdata <= rf_wdata;
            end
            // After a contended grant the loser gets priority next time.
            if (exu_valid && lsu_valid) begin
                rr_ptr_r <= ~rr_ptr_r;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
            busy_r <= busy_nxt_s;
        end
    end

    assign busy = busy_r;

endmodule

// File: tb/tb_npc_wbu.sv
// ---------------------------------------------------------------------------
// tb_npc_wbu
// Self-checking bench for npc_wbu: directed scenarios plus a randomized run
// checked against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_npc_wbu;
    import npc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [31:0] busy;
    logic        exu_valid, exu_ready;
    logic [4:0]  exu_rd;
    logic [31:0] exu_data;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_rdata;
    logic [1:0]  lsu_off;
    logic [2:0]  lsu_funct3;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        commit;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    npc_wbu dut (
        .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_rd(iss_rd), .busy(busy),
        .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_rdata(lsu_rdata),
        .lsu_off(lsu_off), .lsu_funct3(lsu_funct3),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .commit(commit)
    );

    npc_wbu_chk u_chk (
        .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_rd(iss_rd), .busy(busy)
    );

    // Reference load formatting written from the ISA definition.
    function automatic logic [31:0] ref_load(logic [31:0] w, logic [1:0] off, logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*off +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return 32'($signed(b));
            3'b100:  return {24'h0, b};
            3'b001:  return 32'($signed(h));
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        iss_valid = 1'b0; iss_rd = 5'd0;
        exu_valid = 1'b0; exu_rd = 5'd0; exu_data = 32'h0;
        lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_rdata = 32'h0;
        lsu_off = 2'd0; lsu_funct3 = F3_LW;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        exu_valid = 1'b1; lsu_valid = 1'b1;
        tick();
        tick();
        total++; if (exu_ready !== 1'b0) begin bad++; $display("FAIL reset.exu_ready got=%0h want=0", exu_ready); end
        total++; if (lsu_ready !== 1'b0) begin bad++; $display("FAIL reset.lsu_ready got=%0h want=0", lsu_ready); end
        total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL reset.rf_wen got=%0h want=0", rf_wen); end
        total++; if (commit !== 1'b0) begin bad++; $display("FAIL reset.commit got=%0h want=0", commit); end
        total++; if (rf_waddr !== 5'd0) begin bad++; $display("FAIL reset.waddr got=%0h want=0", rf_waddr); end
        total++; if (rf_wdata !== 32'h0) begin bad++; $display("FAIL reset.wdata got=%0h want=0", rf_wdata); end
        total++; if (busy !== 32'h0) begin bad++; $display("FAIL reset.busy got=%0h want=0", busy); end
        clear_inputs();
        rst = 1'b0;
    endtask

    task automatic test_exu_only();
        iss_valid = 1'b1; iss_rd = 5'd5;
        tick();
        iss_valid = 1'b0;
        total++; if (busy !== 32'h20) begin bad++; $display("FAIL exu_only.busy_set got=%0h want=20", busy); end
        exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'h1234;
        #1;
        total++; if (exu_ready !== 1'b1) begin bad++; $display("FAIL exu_only.exu_ready got=%0h want=1", exu_ready); end
        total++; if (lsu_ready !== 1'b0) begin bad++; $display("FAIL exu_only.lsu_ready got=%0h want=0", lsu_ready); end
        tick();
        exu_valid = 1'b0;
        total++; if (rf_wen !== 1'b1) begin bad++; $display("FAIL exu_only.wen got=%0h want=1", rf_wen); end
        total++; if (rf_waddr !== 5'd5) begin bad++; $display("FAIL exu_only.waddr got=%0h want=5", rf_waddr); end
        total++; if (rf_wdata !== 32'h1234) begin bad++; $display("FAIL exu_only.wdata got=%0h want=1234", rf_wdata); end
        total++; if (commit !== 1'b1) begin bad++; $display("FAIL exu_only.commit got=%0h want=1", commit); end
        total++; if (busy !== 32'h20) begin bad++; $display("FAIL exu_only.busy_held got=%0h want=20", busy); end
        tick();
        total++; if (busy !== 32'h0) begin bad++; $display("FAIL exu_only.busy_clr got=%0h want=0", busy); end
        total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL exu_only.wen_idle got=%0h want=0", rf_wen); end
        total++; if (commit !== 1'b0) begin bad++; $display("FAIL exu_only.commit_idle got=%0h want=0", commit); end
        total++; if (rf_wdata !== 32'h1234) begin bad++; $display("FAIL exu_only.wdata_hold got=%0h want=1234", rf_wdata); end
    endtask

    task automatic test_contention();
        logic [31:0] exp_data [3];
        logic [4:0]  exp_rd   [3];
        logic        exp_exu  [3];
        exp_data = '{32'hAAAA0001, 32'h5555BBBB, 32'hAAAA0002};
        exp_rd   = '{5'd1, 5'd2, 5'd1};
        exp_exu  = '{1'b1, 1'b0, 1'b1};
        do_reset();
        exu_valid = 1'b1; exu_rd = 5'd1; exu_data = 32'hAAAA0001;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_rdata = 32'h5555BBBB;
        lsu_off = 2'd0; lsu_funct3 = F3_LW;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (exu_ready !== exp_exu[i]) begin bad++; $display("FAIL contention.exu_ready[%0d] got=%0h want=%0h", i, exu_ready, exp_exu[i]); end
            total++; if (lsu_ready !== !exp_exu[i]) begin bad++; $display("FAIL contention.lsu_ready[%0d] got=%0h want=%0h", i, lsu_ready, !exp_exu[i]); end
            tick();
            if (i == 0) exu_data = 32'hAAAA0002;
            if (i == 2) clear_inputs();
            total++; if (rf_waddr !== exp_rd[i] || rf_wen !== 1'b1) begin bad++; $display("FAIL contention.waddr[%0d] got=%0h want=%0h", i, rf_waddr, exp_rd[i]); end
            total++; if (rf_wdata !== exp_data[i]) begin bad++; $display("FAIL contention.wdata[%0d] got=%0h want=%0h", i, rf_wdata, exp_data[i]); end
        end
        clear_inputs();
    endtask

    task automatic test_load_format();
        logic [1:0]  offs [5];
        logic [2:0]  f3s  [5];
        logic [31:0] exps [5];
        offs = '{2'd0, 2'd2, 2'd3, 2'd2, 2'd0};
        f3s  = '{F3_LB, F3_LB, F3_LBU, F3_LH, F3_LHU};
        exps = '{32'h00000001, 32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
        for (int i = 0; i < 5; i++) begin
            lsu_valid = 1'b1; lsu_rd = 5'(10 + i); lsu_rdata = 32'h80FF7F01;
            lsu_off = offs[i]; lsu_funct3 = f3s[i];
            tick();
            lsu_valid = 1'b0;
            total++; if (rf_wdata !== exps[i] || rf_wen !== 1'b1) begin bad++; $display("FAIL load_fmt[%0d] got=%0h want=%0h", i, rf_wdata, exps[i]); end
        end
        clear_inputs();
    endtask

    task automatic test_x0();
        exu_valid = 1'b1; exu_rd = 5'd0; exu_data = 32'hDEAD;
        tick();
        exu_valid = 1'b0;
        total++; if (commit !== 1'b1) begin bad++; $display("FAIL x0.commit got=%0h want=1", commit); end
        total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL x0.wen got=%0h want=0", rf_wen); end
        tick();
        total++; if (busy !== 32'h0) begin bad++; $display("FAIL x0.busy got=%0h want=0", busy); end
        total++; if (commit !== 1'b0) begin bad++; $display("FAIL x0.commit_idle got=%0h want=0", commit); end
    endtask

    task automatic test_scoreboard();
        iss_valid = 1'b1; iss_rd = 5'd3;
        tick();
        iss_valid = 1'b0;
        total++; if (busy !== 32'h8) begin bad++; $display("FAIL sb.set3 got=%0h want=8", busy); end
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_rdata = 32'hCAFE0003; lsu_off = 2'd0; lsu_funct3 = F3_LW;
        tick();
        lsu_valid = 1'b0;
        total++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd3) begin bad++; $display("FAIL sb.write3 got=%0h want=3", rf_waddr); end
        iss_valid = 1'b1; iss_rd = 5'd7;
        tick();
        iss_valid = 1'b0;
        total++; if (busy !== 32'h80) begin bad++; $display("FAIL sb.clr3_set7 got=%0h want=80", busy); end
        exu_valid = 1'b1; exu_rd = 5'd7; exu_data = 32'h77;
        tick();
        exu_valid = 1'b0;
        total++; if (busy !== 32'h80) begin bad++; $display("FAIL sb.hold7 got=%0h want=80", busy); end
        tick();
        total++; if (busy !== 32'h0) begin bad++; $display("FAIL sb.clr7 got=%0h want=0", busy); end
    endtask

    task automatic test_reset_mid();
        iss_valid = 1'b1; iss_rd = 5'd12;
        tick();
        iss_valid = 1'b0;
        exu_valid = 1'b1; exu_rd = 5'd9; exu_data = 32'h99;
        tick();
        rst = 1'b1; lsu_valid = 1'b1;
        #1;
        total++; if (exu_ready !== 1'b0 || lsu_ready !== 1'b0) begin bad++; $display("FAIL rst_mid.ready got=%0h%0h want=00", exu_ready, lsu_ready); end
        tick();
        total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL rst_mid.wen got=%0h want=0", rf_wen); end
        total++; if (busy !== 32'h0) begin bad++; $display("FAIL rst_mid.busy got=%0h want=0", busy); end
        total++; if (rf_wdata !== 32'h0) begin bad++; $display("FAIL rst_mid.wdata got=%0h want=0", rf_wdata); end
        total++; if (commit !== 1'b0) begin bad++; $display("FAIL rst_mid.commit got=%0h want=0", commit); end
        rst = 1'b0;
        clear_inputs();
        tick();
        total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL rst_mid.no_write got=%0h want=0", rf_wen); end
    endtask

    task automatic test_random();
        logic        m_lsu_pref;
        logic [31:0] m_busy;
        logic        x_wen, x_commit;
        logic [4:0]  x_waddr;
        logic [31:0] x_wdata;
        logic        ev, lv, iv, g_exu, g_lsu;
        logic [4:0]  e_rd, l_rd, i_rd, cand;
        logic [31:0] e_data, l_word;
        logic [1:0]  l_off;
        logic [2:0]  l_f3;
        do_reset();
        m_lsu_pref = 1'b0; m_busy = 32'h0;
        x_wen = 1'b0; x_commit = 1'b0; x_waddr = 5'd0; x_wdata = 32'h0;
        ev = 1'b0; lv = 1'b0;
        e_rd = 5'd0; l_rd = 5'd0; e_data = 32'h0; l_word = 32'h0; l_off = 2'd0; l_f3 = 3'd0;
        for (int c = 0; c < 600; c++) begin
            total++; if (rf_wen !== x_wen) begin bad++; $display("FAIL rand.wen c=%0d got=%0h want=%0h", c, rf_wen, x_wen); end
            total++; if (commit !== x_commit) begin bad++; $display("FAIL rand.commit c=%0d got=%0h want=%0h", c, commit, x_commit); end
            total++; if (busy !== m_busy) begin bad++; $display("FAIL rand.busy c=%0d got=%0h want=%0h", c, busy, m_busy); end
            if (x_wen) begin
                total++; if (rf_waddr !== x_waddr) begin bad++; $display("FAIL rand.waddr c=%0d got=%0h want=%0h", c, rf_waddr, x_waddr); end
                total++; if (rf_wdata !== x_wdata) begin bad++; $display("FAIL rand.wdata c=%0d got=%0h want=%0h", c, rf_wdata, x_wdata); end
            end
            // A waiting producer keeps its payload; otherwise maybe offer a new one.
            if (!ev) begin
                ev = ($urandom_range(2, 0) != 0);
                e_rd = 5'($urandom_range(31, 0)); e_data = $urandom;
            end
            if (!lv) begin
                lv = ($urandom_range(2, 0) != 0);
                l_rd = 5'($urandom_range(31, 0)); l_word = $urandom;
                l_off = 2'($urandom_range(3, 0)); l_f3 = 3'($urandom_range(7, 0));
            end
            iv = 1'b0; i_rd = 5'd0;
            if ($urandom_range(2, 0) == 0) begin
                cand = 5'($urandom_range(31, 1));
                if (!m_busy[cand]) begin iv = 1'b1; i_rd = cand; end
            end
            exu_valid = ev; exu_rd = e_rd; exu_data = e_data;
            lsu_valid = lv; lsu_rd = l_rd; lsu_rdata = l_word; lsu_off = l_off; lsu_funct3 = l_f3;
            iss_valid = iv; iss_rd = i_rd;
            #1;
            if (ev && lv) begin
                g_lsu = m_lsu_pref; g_exu = !m_lsu_pref;
                m_lsu_pref = g_exu;
            end else begin
                g_exu = ev; g_lsu = lv;
            end
            total++; if (exu_ready !== g_exu) begin bad++; $display("FAIL rand.exu_ready c=%0d got=%0h want=%0h", c, exu_ready, g_exu); end
            total++; if (lsu_ready !== g_lsu) begin bad++; $display("FAIL rand.lsu_ready c=%0d got=%0h want=%0h", c, lsu_ready, g_lsu); end
            if (x_wen) m_busy[x_waddr] = 1'b0;
            if (iv) m_busy[i_rd] = 1'b1;
            if (g_exu) begin
                x_commit = 1'b1; x_wen = (e_rd != 5'd0); x_waddr = e_rd; x_wdata = e_data; ev = 1'b0;
            end else if (g_lsu) begin
                x_commit = 1'b1; x_wen = (l_rd != 5'd0); x_waddr = l_rd;
                x_wdata = ref_load(l_word, l_off, l_f3); lv = 1'b0;
            end else begin
                x_commit = 1'b0; x_wen = 1'b0;
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_exu_only();
        test_contention();
        test_load_format();
        test_x0();
        test_scoreboard();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
